// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access at a time, req/gnt/rvalid memory handshake,
// store lane replication, load alignment with sign/zero extension and timeout abort.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic        core_we,
  input  logic [2:0]  core_func3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  func3_q, func3_nxt;
  logic [1:0]  off_q, off_nxt;
  logic        resp_valid_nxt, resp_err_nxt, mem_req_nxt, mem_we_nxt;
  logic [31:0] resp_rdata_nxt, mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]  mem_be_nxt;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3[2] || f3 == 3'b011);
    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [31:0] w;
    w = rd >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'b0, w[7:0]};
      3'b101:  return {16'b0, w[15:0]};
      default: return rd;
    endcase
  endfunction

  assign core_ready = (state == IDLE) & rst_n;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    func3_nxt      = func3_q;
    off_nxt        = off_q;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = 32'b0;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_be_nxt     = mem_be;
    mem_wdata_nxt  = mem_wdata;
    case (state)
      IDLE: begin
        if (core_valid) begin
          if (is_illegal(core_we, core_func3) || is_misaligned(core_func3, core_addr[1:0])) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else begin
            state_nxt     = REQ;
            cnt_nxt       = 16'd0;
            func3_nxt     = core_func3;
            off_nxt       = core_addr[1:0];
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = core_we;
            mem_addr_nxt  = {core_addr[31:2], 2'b00};
            mem_be_nxt    = core_we ? store_be(core_func3, core_addr[1:0]) : 4'b1111;
            mem_wdata_nxt = store_data(core_func3, core_wdata);
          end
        end
      end
      REQ: begin
        cnt_nxt = cnt + 16'd1;
        if (mem_gnt) begin
          mem_req_nxt = 1'b0;
          if (mem_we) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end else if (cnt == CNT_LAST) begin
          mem_req_nxt    = 1'b0;
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + 16'd1;
        if (mem_rvalid) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = load_extract(func3_q, off_q, mem_rdata);
        end else if (cnt == CNT_LAST) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every output except core_ready is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      func3_q    <= 3'b0;
      off_q      <= 2'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'b0;
      mem_be     <= 4'b0;
      mem_wdata  <= 32'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      func3_q    <= func3_nxt;
      off_q      <= off_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
      busy       <= (state_nxt != IDLE);
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_be     <= mem_be_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a default instance plus a TIMEOUT_CYCLES=4 instance
// selected by sel_to; inputs driven and outputs sampled on the falling edge.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_valid, core_we, sel_to;
  logic [2:0]  core_func3;
  logic [31:0] core_addr, core_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        core_ready, resp_valid, resp_err, busy, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        t_core_ready, t_resp_valid, t_resp_err, t_busy, t_mem_req, t_mem_we;
  logic [31:0] t_resp_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_be;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .core_valid(core_valid & ~sel_to), .core_ready(core_ready),
    .core_we(core_we), .core_func3(core_func3), .core_addr(core_addr), .core_wdata(core_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .core_valid(core_valid & sel_to), .core_ready(t_core_ready),
    .core_we(core_we), .core_func3(core_func3), .core_addr(core_addr), .core_wdata(core_wdata),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err), .busy(t_busy),
    .mem_req(t_mem_req), .mem_gnt(mem_gnt), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
    .mem_be(t_mem_be), .mem_wdata(t_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    core_valid = 1'b1;
    core_we    = we;
    core_func3 = f3;
    core_addr  = a;
    core_wdata = wd;
    tick();
    core_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    chk({tag, ".ready"}, 32'(core_ready), 1);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, ".req"}, 32'(mem_req), 1);
    chk({tag, ".we"}, 32'(mem_we), 0);
    chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, ".be"}, 32'(mem_be), 32'hF);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, ".req_drop"}, 32'(mem_req), 0);
    chk({tag, ".early_resp"}, 32'(resp_valid), 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, ".resp"}, 32'(resp_valid), 1);
    chk({tag, ".err"}, 32'(resp_err), 0);
    chk({tag, ".rdata"}, resp_rdata, exp);
    tick();
    chk({tag, ".resp_once"}, 32'(resp_valid), 0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b1, f3, a, wd);
    chk({tag, ".req"}, 32'(mem_req), 1);
    chk({tag, ".we"}, 32'(mem_we), 1);
    chk({tag, ".addr"}, mem_addr, exp_addr);
    chk({tag, ".be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, ".wdata"}, mem_wdata, exp_wd);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, ".resp"}, 32'(resp_valid), 1);
    chk({tag, ".err"}, 32'(resp_err), 0);
    chk({tag, ".rdata"}, resp_rdata, 0);
    chk({tag, ".req_drop"}, 32'(mem_req), 0);
    tick();
    chk({tag, ".resp_once"}, 32'(resp_valid), 0);
  endtask

  task automatic do_bad(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a);
    issue(we, f3, a, 32'hFFFF_FFFF);
    chk({tag, ".resp"}, 32'(resp_valid), 1);
    chk({tag, ".err"}, 32'(resp_err), 1);
    chk({tag, ".rdata"}, resp_rdata, 0);
    chk({tag, ".no_req"}, 32'(mem_req), 0);
    tick();
    chk({tag, ".resp_once"}, 32'(resp_valid), 0);
    chk({tag, ".no_req2"}, 32'(mem_req), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    core_valid = 1'b0; core_we = 1'b0; core_func3 = 3'b0; core_addr = 32'h0;
    core_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; sel_to = 1'b0;
    repeat (2) tick();
    chk("rst.ready", 32'(core_ready), 0);
    chk("rst.resp", 32'(resp_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.req", 32'(mem_req), 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.be", 32'(mem_be), 0);
    rst_n = 1'b1;
    tick();

    // Stray gnt/rvalid while idle must do nothing
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("idle.busy", 32'(busy), 0);
    chk("idle.resp", 32'(resp_valid), 0);

    do_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001);
    do_load("lw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb_pos", 3'b000, 32'h0000_0100, 32'h0000_007F, 32'h0000_007F);

    do_store("sb", 3'b000, 32'h0000_0021, 32'h1234_56AB, 32'h0000_0020, 4'b0010, 32'hABAB_ABAB);
    do_store("sh", 3'b001, 32'h0000_0042, 32'h0000_CAFE, 32'h0000_0040, 4'b1100, 32'hCAFE_CAFE);
    do_store("sw", 3'b010, 32'h0000_0080, 32'h1234_5678, 32'h0000_0080, 4'b1111, 32'h1234_5678);

    do_bad("lw_mis", 1'b0, 3'b010, 32'h0000_0102);
    do_bad("lh_mis", 1'b0, 3'b001, 32'h0000_0101);
    do_bad("ld_f011", 1'b0, 3'b011, 32'h0000_0100);
    do_bad("st_f100", 1'b1, 3'b100, 32'h0000_0100);

    // Grant withheld for three cycles; request fields must hold steady
    issue(1'b1, 3'b001, 32'h0000_0046, 32'h0000_BEEF);
    for (int i = 0; i < 3; i++) begin
      chk("dly.req", 32'(mem_req), 1);
      chk("dly.addr", mem_addr, 32'h0000_0044);
      chk("dly.be", 32'(mem_be), 32'hC);
      chk("dly.wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("dly.resp", 32'(resp_valid), 0);
      core_valid = 1'b1;
      tick();
      core_valid = 1'b0;
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("dly.done", 32'(resp_valid), 1);
    chk("dly.req_drop", 32'(mem_req), 0);
    tick();
    chk("dly.idle", 32'(busy), 0);

    // Reset while waiting for read data
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rstw.busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rstw.req", 32'(mem_req), 0);
    chk("rstw.busy", 32'(busy), 0);
    chk("rstw.ready", 32'(core_ready), 0);
    chk("rstw.addr", mem_addr, 0);
    mem_rvalid = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("rstw.no_resp", 32'(resp_valid), 0);
    chk("rstw.ready_after", 32'(core_ready), 1);

    // Timeout on the TIMEOUT_CYCLES=4 instance
    sel_to = 1'b1;
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    chk("to.req", 32'(t_mem_req), 1);
    chk("to.main_idle", 32'(busy), 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("to.pending", 32'(t_resp_valid), 0);
      chk("to.busy", 32'(t_busy), 1);
      tick();
    end
    chk("to.resp", 32'(t_resp_valid), 1);
    chk("to.err", 32'(t_resp_err), 1);
    chk("to.rdata", t_resp_rdata, 0);
    chk("to.req", 32'(t_mem_req), 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk("to.late_rvalid", 32'(t_resp_valid), 0);
    chk("to.idle", 32'(t_busy), 0);
    sel_to = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
